// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory behind a val/rdy request/response
// pair. One request in flight; the response appears LATENCY cycles after
// accept and is held until the consumer takes it.
module dmem_responder #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_type,
    input  logic [31:0] memreq_addr,
    input  logic [31:0] memreq_wdata,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_type,
    output logic [31:0] memresp_data
);

    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [WORDS];
    logic [AW-1:0] idx;
    logic          accept;
    logic          resp_type_q;
    logic [31:0]   resp_data_q;

    // Byte address -> word index; low two bits and bits above the array are dropped.
    assign idx = memreq_addr[AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{memreq_addr[31:AW+2], memreq_addr[1:0]};

    assign memresp_type = resp_type_q;
    assign memresp_data = resp_data_q;

    // Next-state and handshake outputs; reset masks both ready and valid.
    always_comb begin
        state_nxt   = state;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                memreq_rdy = !rst;
                accept     = memreq_val && !rst;
                if (accept)
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == CW'(1))
                    state_nxt = RESP;
            end
            RESP: begin
                memresp_val = !rst;
                if (memresp_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, delay counter and registered response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            resp_type_q <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                resp_type_q <= memreq_type;
                resp_data_q <= memreq_type ? 32'h0 : mem[idx];
                cnt         <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Storage is never cleared; a write commits on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && memreq_type)
            mem[idx] <= memreq_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 4) exercised one
// at a time; a reference memory produces expected responses into a queue
// that a monitor drains as responses are handshaken.
module tb_dmem_responder;

    localparam int N = 3;

    typedef struct packed {
        logic        t;
        logic [31:0] d;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_val, req_rdy, req_type;
    logic [N-1:0][31:0]    req_addr, req_wdata;
    logic [N-1:0]          resp_val, resp_rdy, resp_type;
    logic [N-1:0][31:0]    resp_data;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur = 0;
    int          acc_cyc = 0;
    bit          lat_armed = 0;
    exp_t        sb[$];
    logic [31:0] mdl [N][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .WORDS   (256),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .memreq_val   (req_val[g]),
            .memreq_rdy   (req_rdy[g]),
            .memreq_type  (req_type[g]),
            .memreq_addr  (req_addr[g]),
            .memreq_wdata (req_wdata[g]),
            .memresp_val  (resp_val[g]),
            .memresp_rdy  (resp_rdy[g]),
            .memresp_type (resp_type[g]),
            .memresp_data (resp_data[g])
        );
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (inst %0d cyc %0d)", tag, got, exp, cur, cyc);
        end
    endtask

    // Response monitor: every cycle a response is shown it must match the queue head.
    always @(negedge clk) begin
        if (resp_val[cur]) begin
            if (lat_armed) begin
                chk("latency", 32'(cyc - acc_cyc), 32'(lat_of(cur)));
                lat_armed = 0;
            end
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                chk("resp_type", 32'(resp_type[cur]), 32'(sb[0].t));
                chk("resp_data", resp_data[cur], sb[0].d);
                if (resp_rdy[cur]) void'(sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic req(int i, logic t, logic [31:0] a, logic [31:0] d, output int acc);
        int   n;
        bit   ok;
        exp_t e;
        n = 0; ok = 0; acc = -1;
        req_val[i] = 1'b1; req_type[i] = t; req_addr[i] = a; req_wdata[i] = d;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (req_rdy[i]) begin
                ok = 1; acc = cyc; acc_cyc = cyc; lat_armed = 1;
                e.t = t;
                e.d = t ? 32'h0 : mdl[i][widx(a)];
                sb.push_back(e);
                if (t) mdl[i][widx(a)] = d;
            end
            n++;
            @(posedge clk); #1;
        end
        req_val[i] = 1'b0;
        chk("req_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_resp_val(int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_val[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout", 32'(resp_val[i]), 32'd1);
    endtask

    // Request blocked for LATENCY cycles after accept, then ready again.
    task automatic rdy_probe(int i);
        for (int k = 1; k <= lat_of(i); k++) begin
            @(negedge clk);
            chk("busy_rdy", 32'(req_rdy[i]), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rdy_back", 32'(req_rdy[i]), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int a, prev;
        logic [31:0] d;
        rst = 1'b1;
        req_val = '0; req_type = '0; req_addr = '0; req_wdata = '0;
        resp_rdy = '1;

        // Reset state, while asserted and in the cycle after.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_rdy", 32'(req_rdy[i]), 32'd0);
            chk("rst_val", 32'(resp_val[i]), 32'd0);
            chk("rst_type", 32'(resp_type[i]), 32'd0);
            chk("rst_data", resp_data[i], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("post_rst_rdy", 32'(req_rdy[i]), 32'd1);
            chk("post_rst_val", 32'(resp_val[i]), 32'd0);
            chk("post_rst_data", resp_data[i], 32'd0);
        end
        @(posedge clk); #1;

        // LATENCY=1: write then read back, wrap-around and low-bit ignore.
        cur = 0;
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, a);
        req(0, 1'b0, 32'h10, 32'h0, a);
        drain();
        req(0, 1'b1, 32'h400, 32'h1234, a);
        req(0, 1'b0, 32'h0, 32'h0, a);
        req(0, 1'b0, 32'h3, 32'h0, a);
        drain();

        // Request in the same cycle as reset must not write.
        req(0, 1'b1, 32'h30, 32'h11111111, a);
        drain();
        req_val[0] = 1'b1; req_type[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h22222222;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_val[0] = 1'b0;
        @(negedge clk);
        chk("rst_req_noresp", 32'(resp_val[0]), 32'd0);
        @(posedge clk); #1;
        req(0, 1'b0, 32'h30, 32'h0, a);
        drain();

        // Backpressure: held 5 cycles, handshake on the 6th.
        resp_rdy[0] = 1'b0;
        req(0, 1'b0, 32'h10, 32'h0, a);
        wait_resp_val(0);
        repeat (4) begin
            @(negedge clk);
            chk("hold_val", 32'(resp_val[0]), 32'd1);
        end
        @(posedge clk); #1;
        resp_rdy[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_rdy_after", 32'(req_rdy[0]), 32'd1);
        chk("hold_val_after", 32'(resp_val[0]), 32'd0);
        @(posedge clk); #1;

        // LATENCY=2: back-to-back requests accepted every 3 cycles.
        cur = 1;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            req(1, (k % 2 == 0), 32'h40 + 32'((k / 2) * 4), $urandom, a);
            if (k > 0) chk("stream_period", 32'(a - prev), 32'd3);
            prev = a;
        end
        drain();

        // LATENCY=2: random mix over a pre-written window.
        for (int k = 0; k < 8; k++) req(1, 1'b1, 32'(k * 4), $urandom, a);
        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            req(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), d, a);
        end
        drain();

        // LATENCY=4: busy window on write and read.
        cur = 2;
        req(2, 1'b1, 32'h8, 32'hCAFEF00D, a);
        rdy_probe(2);
        req(2, 1'b0, 32'h8, 32'h0, a);
        rdy_probe(2);
        chk("sb_after_probe", 32'(sb.size()), 32'd0);

        // Reset while waiting: response dropped, write kept.
        req(2, 1'b1, 32'h20, 32'hA5A5A5A5, a);
        rst = 1'b1;
        sb.delete();
        lat_armed = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_rdy", 32'(req_rdy[2]), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_noresp", 32'(resp_val[2]), 32'd0);
        end
        @(posedge clk); #1;
        req(2, 1'b0, 32'h20, 32'h0, a);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
